// File: rtl/sel_arb_pkg.sv
// Shared constants and state type for the round-robin select arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sel_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    GRANT = 2'd2,
    GUARD = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sel_rr_arbiter_if.sv
// Request/select bundle between requesters, the arbiter and the board selects.
// Latency: n/a (wiring only).
// Backpressure: none; requesters hold req high for as long as they own the bus.
//
// Signals:
//   req     requester -> arbiter, request levels
//   sel     arbiter -> board, encoded owner index
//   sel_en  arbiter -> board, high while y_n[sel] is low
//   y_n     arbiter -> board, active-low one-hot selects
//   busy    arbiter -> requesters, arbiter not idle
//   timeout arbiter -> requesters, one-cycle watchdog release pulse
// Modports: master = arbiter side, slave = requester/board side.
interface sel_rr_arbiter_if;
  import sel_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [SEL_W-1:0]   sel;
  logic               sel_en;
  logic [NUM_REQ-1:0] y_n;
  logic               busy;
  logic               timeout;

  modport master (
    input  req,
    output sel,
    output sel_en,
    output y_n,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    input  sel,
    input  sel_en,
    input  y_n,
    input  busy,
    input  timeout
  );

endinterface

// File: rtl/part_74S138.sv
// Behavioural model of the 74S138 3-to-8 decoder with active-low outputs.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   a,b,c      in  1  select address (a = LSB)
//   g1         in  1  active-high enable
//   g2a_n      in  1  active-low enable
//   g2b_n      in  1  active-low enable
//   y_n        out 8  decoded outputs, all high unless fully enabled
module part_74S138 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       g1,
  input  logic       g2a_n,
  input  logic       g2b_n,
  output logic [7:0] y_n
);

  logic       en;
  logic [2:0] addr;

  assign en   = g1 & ~g2a_n & ~g2b_n;
  assign addr = {c, b, a};
  assign y_n  = en ? ~(8'b1 << addr) : 8'hFF;

endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first eligible request after 'last', wrapping mod 8.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   req  in  8  request levels
//   mask in  8  requesters excluded from this search
//   last in  3  previous owner; search starts at last+1
//   idx  out 3  chosen index (only meaningful when any=1)
//   any  out 1  at least one eligible request
module rr_pick8
  import sel_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] cand;

  assign cand = req & ~mask;
  assign any  = |cand;

  // Walk from lowest priority (last itself, k=8) up to highest (last+1) so
  // the final overwrite leaves the highest-priority hit.  The 3-bit add
  // wraps naturally, giving the mod-8 search order.
  always_comb begin
    logic [SEL_W-1:0] pos;
    idx = last;
    pos = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = last + SEL_W'(k);
      if (cand[pos]) begin
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/sel_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 select decoder among 8 requesters.
// Latency: request sampled in IDLE -> SETUP -> GRANT (y_n low) two edges later.
// Backpressure: owner keeps req high to hold; release/abort insert GUARD_CYCLES of all-high selects.
//
// Ports:
//   clk      in  1  system clock
//   reset_n  in  1  asynchronous active-low reset
//   bus      sel_rr_arbiter_if.master (req in; sel, sel_en, y_n, busy, timeout out)
// Parameters: GUARD_CYCLES (>=1), TO_WIDTH, HOLD_MAX (< 2**TO_WIDTH).
// Optional macro SEL_TIMEOUT_EN: hold-time watchdog with per-requester lockout.
module sel_rr_arbiter
  import sel_arb_pkg::*;
#(
  parameter int GUARD_CYCLES = 1,
  parameter int TO_WIDTH     = 8,
  parameter int HOLD_MAX     = 200
) (
  input  logic              clk,
  input  logic              reset_n,
  sel_rr_arbiter_if.master  bus
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  // Parameter sanity: an illegal combination elaborates this marker block,
  // which shows up in the hierarchy of any build that gets it wrong.
  if (GUARD_CYCLES < 1 || HOLD_MAX < 1 || HOLD_MAX >= (1 << TO_WIDTH)) begin : g_bad_params
  end

  arb_state_t         state_q, state_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic [SEL_W-1:0]   last_q,  last_d;
  logic [GW-1:0]      guard_q, guard_d;
  logic [NUM_REQ-1:0] mask;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic               sel_en;

`ifdef SEL_TIMEOUT_EN
  logic [TO_WIDTH-1:0] wd_q,   wd_d;
  logic [NUM_REQ-1:0]  lock_q, lock_d;
  logic                to_q,   to_d;

  assign mask = lock_q;
`else
  assign mask = '0;
`endif

  rr_pick8 u_pick (
    .req  (bus.req),
    .mask (mask),
    .last (last_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // State register.  Everything the outputs depend on is here, so an async
  // reset drops the selects immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      guard_q <= '0;
`ifdef SEL_TIMEOUT_EN
      wd_q    <= '0;
      lock_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      guard_q <= guard_d;
`ifdef SEL_TIMEOUT_EN
      wd_q    <= wd_d;
      lock_q  <= lock_d;
      to_q    <= to_d;
`endif
    end
  end

  // Next-state logic.  Every way into GUARD records the owner as 'last' so
  // the next search starts just after it, even for an aborted SETUP.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    guard_d = guard_q;
`ifdef SEL_TIMEOUT_EN
    wd_d    = wd_q;
    lock_d  = lock_q & bus.req;  // lockout lifts once the requester lets go
    to_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (bus.req[sel_q]) begin
          state_d = GRANT;
`ifdef SEL_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          state_d = GUARD;
          guard_d = '0;
          last_d  = sel_q;
        end
      end

      GRANT: begin
        if (!bus.req[sel_q]) begin
          state_d = GUARD;
          guard_d = '0;
          last_d  = sel_q;
        end
`ifdef SEL_TIMEOUT_EN
        else if (wd_q == TO_WIDTH'(HOLD_MAX - 1)) begin
          // Owner overstayed: force release and keep it out of the search
          // until it drops its request.
          state_d        = GUARD;
          guard_d        = '0;
          last_d         = sel_q;
          to_d           = 1'b1;
          lock_d[sel_q]  = 1'b1;
        end else begin
          wd_d = wd_q + TO_WIDTH'(1);
        end
`endif
      end

      GUARD: begin
        if (guard_q == GW'(GUARD_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign sel_en   = (state_q == GRANT);
  assign bus.sel    = sel_q;
  assign bus.sel_en = sel_en;
  assign bus.busy   = (state_q != IDLE);
`ifdef SEL_TIMEOUT_EN
  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif

  // Address lines come straight from the registered owner and only the
  // G1 enable toggles, so no decoder output can glitch low.
  part_74S138 u_dec (
    .a     (sel_q[0]),
    .b     (sel_q[1]),
    .c     (sel_q[2]),
    .g1    (sel_en),
    .g2a_n (1'b0),
    .g2b_n (1'b0),
    .y_n   (bus.y_n)
  );

endmodule

// File: tb/tb_sel_rr_arbiter.sv
// Self-checking bench for sel_rr_arbiter: directed steps then random requests
// compared each cycle against a transaction-level owner/phase model.
// Timeout scenario only runs when SEL_TIMEOUT_EN is defined.
module tb_sel_rr_arbiter;

  localparam int GC = 1;
`ifdef SEL_TIMEOUT_EN
  localparam int HM    = 4;
  localparam bit TO_ON = 1'b1;
`else
  localparam int HM    = 200;
  localparam bit TO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  sel_rr_arbiter_if bus ();

  sel_rr_arbiter #(
    .GUARD_CYCLES (GC),
    .TO_WIDTH     (8),
    .HOLD_MAX     (HM)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = nobody chosen, 1 = address settling,
  // 2 = owner holds the bus, 3 = gap before the next search.
  int         m_phase = 0;
  int         m_owner = 0;
  int         m_last  = 7;
  int         m_gap   = 0;
  int         m_hold  = 0;
  logic [7:0] m_lock  = 8'h00;
  logic       m_to    = 1'b0;
  logic [7:0] mr;
  int         mi;
  bit         m_setlock;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_owner = 0; m_last = 7; m_gap = 0; m_hold = 0;
      m_lock = 8'h00; m_to = 1'b0;
    end else begin
      mr = bus.req;
      m_to = 1'b0;
      m_setlock = 1'b0;
      case (m_phase)
        0: begin
          for (int k = 1; k <= 8; k++) begin
            mi = (m_last + k) % 8;
            if (mr[mi] && !m_lock[mi]) begin
              m_owner = mi;
              m_phase = 1;
              break;
            end
          end
        end
        1: begin
          if (mr[m_owner]) begin
            m_phase = 2; m_hold = 0;
          end else begin
            m_phase = 3; m_gap = GC; m_last = m_owner;
          end
        end
        2: begin
          if (!mr[m_owner]) begin
            m_phase = 3; m_gap = GC; m_last = m_owner;
          end else begin
            m_hold = m_hold + 1;
            if (TO_ON && m_hold == HM) begin
              m_phase = 3; m_gap = GC; m_last = m_owner;
              m_to = 1'b1; m_setlock = 1'b1;
            end
          end
        end
        default: begin
          m_gap = m_gap - 1;
          if (m_gap == 0) m_phase = 0;
        end
      endcase
      m_lock = m_lock & mr;
      if (m_setlock) m_lock[m_owner] = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic [7:0] ey;
    ey = (m_phase == 2) ? ~(8'(1) << m_owner) : 8'hFF;
    chk("y_n", bus.y_n, ey);
    chk("sel_en", bus.sel_en, (m_phase == 2));
    chk("busy", bus.busy, (m_phase != 0));
    chk("sel", bus.sel, m_owner[2:0]);
    chk("timeout", bus.timeout, m_to);
    chk("onehot", ($countones(~bus.y_n) <= 1), 1);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic wait_grant(output int owner, output int edges);
    owner = -1;
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      edges++;
      if (bus.sel_en === 1'b1) begin
        owner = int'(bus.sel);
        break;
      end
    end
    total++;
    assert (owner >= 0) else begin
      bad++;
      $error("FAIL grant_wait observed=none expected=grant_within_40");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "bench timeout");
  end

  int         own, edg, cnt;
  int         exp_rot [4] = '{0, 7, 0, 7};
  logic [7:0] rq;

  initial begin
    bus.req = 8'hFF;
    reset_n = 1'b0;

    // Reset with every request active: selects stay idle.
    repeat (2) step();
    chk("rst_y_n", bus.y_n, 8'hFF);
    chk("rst_busy", bus.busy, 0);
    reset_n = 1'b1;
    wait_grant(own, edg);
    chk("rst_first_owner", own, 0);
    chk("rst_latency", edg, 2);
    bus.req = 8'h00;
    repeat (4) step();

    // Single requester.
    bus.req = 8'h08;
    wait_grant(own, edg);
    chk("single_owner", own, 3);
    chk("single_latency", edg, 2);
    chk("single_y_n", bus.y_n, 8'hF7);
    bus.req = 8'h00;
    step();
    chk("single_release", bus.y_n, 8'hFF);
    repeat (3) step();

    // Rotation between 0 and 7 from a fresh reset.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    bus.req = 8'h81;
    for (int i = 0; i < 4; i++) begin
      wait_grant(own, edg);
      chk("rot_owner", own, exp_rot[i]);
      if (i > 0) chk("rot_gap", edg, GC + 2);
      rq = 8'h81;
      rq[own[2:0]] = 1'b0;
      bus.req = rq;
      step();
      bus.req = 8'h81;
    end
    bus.req = 8'h00;
    repeat (5) step();

    // Request withdrawn during SETUP: no select is ever driven.
    bus.req = 8'h04;
    step();
    bus.req = 8'h00;
    chk("abort_sel", bus.sel, 2);
    chk("abort_busy_setup", bus.busy, 1);
    step();
    chk("abort_y_n_guard", bus.y_n, 8'hFF);
    chk("abort_busy_guard", bus.busy, 1);
    step();
    chk("abort_idle", bus.busy, 0);

`ifdef SEL_TIMEOUT_EN
    // Hold-time watchdog with lockout until the request drops.
    bus.req = 8'h02;
    wait_grant(own, edg);
    cnt = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.sel_en === 1'b1) cnt++;
      else break;
    end
    chk("to_hold_cycles", cnt, HM);
    chk("to_pulse", bus.timeout, 1);
    chk("to_y_n", bus.y_n, 8'hFF);
    repeat (8) step();
    chk("to_no_regrant", bus.busy, 0);
    bus.req = 8'h00;
    step();
    bus.req = 8'h02;
    wait_grant(own, edg);
    chk("to_regrant_owner", own, 1);
    bus.req = 8'h00;
    repeat (4) step();
`endif

    // Async reset while granted: selects release without waiting for an edge.
    bus.req = 8'h20;
    wait_grant(own, edg);
    chk("async_pre_owner", own, 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_y_n", bus.y_n, 8'hFF);
    chk("async_sel_en", bus.sel_en, 0);
    chk("async_busy", bus.busy, 0);
    check_cycle();
    step();
    bus.req = 8'h00;
    reset_n = 1'b1;
    step();

    // Random request traffic against the model.
    rq = 8'h00;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      end
      bus.req = rq;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
